// File: rtl/px_pkg.sv
// Shared definitions for the pixel conversion stage: mode encodings,
// luma weights and channel slicing helpers.
package px_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_AVG    = 2'd1,
        MODE_LUMA   = 2'd2,
        MODE_THRESH = 2'd3
    } mode_t;

    // Weights sum to 2**LUMA_SHIFT, so the shifted luma never exceeds full scale
    localparam int LUMA_WR    = 77;
    localparam int LUMA_WG    = 150;
    localparam int LUMA_WB    = 29;
    localparam int LUMA_SHIFT = 8;

    localparam int CH_R = 2;
    localparam int CH_G = 1;
    localparam int CH_B = 0;

    function automatic int chan_lsb(input int ch, input int pix_w);
        return ch * pix_w;
    endfunction

endpackage

// File: rtl/pixel_convert_stage_if.sv
// Input-FIFO read side and output-FIFO write side of the conversion stage.
interface pixel_convert_stage_if #(
    parameter int PIX_W = 8
);
    logic                 fifo_in_rd_en;
    logic [3*PIX_W-1:0]   fifo_in_dout;
    logic                 fifo_in_empty;
    logic                 fifo_out_wr_en;
    logic [3*PIX_W-1:0]   fifo_out_din;
    logic                 fifo_out_full;

    modport master (
        output fifo_in_rd_en,
        input  fifo_in_dout,
        input  fifo_in_empty,
        output fifo_out_wr_en,
        output fifo_out_din,
        input  fifo_out_full
    );

    modport slave (
        input  fifo_in_rd_en,
        output fifo_in_dout,
        output fifo_in_empty,
        input  fifo_out_wr_en,
        input  fifo_out_din,
        output fifo_out_full
    );
endinterface

// File: rtl/pixel_convert_core.sv
// Combinational per-pixel conversion: passthrough, average gray, luma gray
// or binary threshold on luma.
module pixel_convert_core
    import px_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  mode_t               mode,
    input  logic [PIX_W-1:0]    thresh,
    input  logic [3*PIX_W-1:0]  pix_in,
    output logic [3*PIX_W-1:0]  pix_out
);
    localparam int SUM_W = PIX_W + 2;
    localparam int ACC_W = PIX_W + 8;

    logic [PIX_W-1:0] r, g, b;
    logic [SUM_W-1:0] sum;
    logic [ACC_W-1:0] luma_acc;
    logic [PIX_W-1:0] avg, luma, gray;

    assign r = pix_in[chan_lsb(CH_R, PIX_W) +: PIX_W];
    assign g = pix_in[chan_lsb(CH_G, PIX_W) +: PIX_W];
    assign b = pix_in[chan_lsb(CH_B, PIX_W) +: PIX_W];

    // True division keeps the average exact for every input combination
    assign sum      = SUM_W'(r) + SUM_W'(g) + SUM_W'(b);
    assign avg      = PIX_W'(sum / SUM_W'(3));
    assign luma_acc = ACC_W'(LUMA_WR) * ACC_W'(r)
                    + ACC_W'(LUMA_WG) * ACC_W'(g)
                    + ACC_W'(LUMA_WB) * ACC_W'(b);
    assign luma     = PIX_W'(luma_acc >> LUMA_SHIFT);

    always_comb begin
        gray = '0;
        case (mode)
            MODE_AVG:    gray = avg;
            MODE_LUMA:   gray = luma;
            MODE_THRESH: gray = (luma >= thresh) ? '1 : '0;
            default:     gray = '0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            assign pix_out[gi*PIX_W +: PIX_W] =
                (mode == MODE_PASS) ? pix_in[gi*PIX_W +: PIX_W] : gray;
        end
    endgenerate

endmodule

// File: rtl/pixel_convert_stage.sv
// Two-stage streaming colour converter between an FWFT input FIFO and an
// output FIFO, with per-frame mode latching and frame-done signalling.
module pixel_convert_stage
    import px_pkg::*;
#(
    parameter int PIX_W        = 8,
    parameter int FRAME_PIXELS = 76800,
    parameter int CNT_W        = 17
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic [PIX_W-1:0]      thresh,
    pixel_convert_stage_if.master fifo,
    output logic                  frame_done,
    output logic [CNT_W-1:0]      pixel_count
);
    logic                 s1_valid_reg, s2_valid_reg;
    logic [3*PIX_W-1:0]   s1_pix_reg, s2_pix_reg;
    mode_t                s1_mode_reg;
    logic [PIX_W-1:0]     s1_thresh_reg;
    logic                 s1_eof_reg, s2_eof_reg;
    mode_t                mode_lat_reg;
    logic [PIX_W-1:0]     thresh_lat_reg;
    logic [CNT_W-1:0]     count_reg;
    logic                 frame_done_reg;

    logic                 adv1, adv2, rd_en, wr_en;
    logic                 first_pix, last_pix;
    mode_t                mode_sel;
    logic [PIX_W-1:0]     thresh_sel;
    logic [3*PIX_W-1:0]   conv_pix;
    logic [CNT_W-1:0]     count_next;

    assign adv2  = !s2_valid_reg || !fifo.fifo_out_full;
    assign adv1  = !s1_valid_reg || adv2;
    assign rd_en = !reset && !fifo.fifo_in_empty && adv1;
    assign wr_en = !reset && s2_valid_reg && !fifo.fifo_out_full;

    assign first_pix  = (count_reg == '0);
    assign last_pix   = (count_reg == CNT_W'(FRAME_PIXELS - 1));
    assign count_next = last_pix ? '0 : count_reg + CNT_W'(1);

    // The first pixel of a frame already uses the freshly sampled settings
    assign mode_sel   = first_pix ? mode_t'(mode) : mode_lat_reg;
    assign thresh_sel = first_pix ? thresh : thresh_lat_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_reg   <= 1'b0;
            s1_pix_reg     <= '0;
            s1_mode_reg    <= MODE_PASS;
            s1_thresh_reg  <= '0;
            s1_eof_reg     <= 1'b0;
            mode_lat_reg   <= MODE_PASS;
            thresh_lat_reg <= '0;
            count_reg      <= '0;
        end else begin
            if (adv1) begin
                s1_valid_reg <= rd_en;
            end
            if (rd_en) begin
                s1_pix_reg    <= fifo.fifo_in_dout;
                s1_mode_reg   <= mode_sel;
                s1_thresh_reg <= thresh_sel;
                s1_eof_reg    <= last_pix;
                count_reg     <= count_next;
                if (first_pix) begin
                    mode_lat_reg   <= mode_sel;
                    thresh_lat_reg <= thresh_sel;
                end
            end
        end
    end

    pixel_convert_core #(
        .PIX_W (PIX_W)
    ) u_core (
        .mode    (s1_mode_reg),
        .thresh  (s1_thresh_reg),
        .pix_in  (s1_pix_reg),
        .pix_out (conv_pix)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid_reg   <= 1'b0;
            s2_pix_reg     <= '0;
            s2_eof_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            if (adv2) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    s2_pix_reg <= conv_pix;
                    s2_eof_reg <= s1_eof_reg;
                end
            end
            frame_done_reg <= wr_en && s2_eof_reg;
        end
    end

    assign fifo.fifo_in_rd_en  = rd_en;
    assign fifo.fifo_out_wr_en = wr_en;
    assign fifo.fifo_out_din   = s2_pix_reg;
    assign frame_done          = frame_done_reg;
    assign pixel_count         = count_reg;

endmodule

// File: tb/tb_pixel_convert_stage.sv
// Self-checking bench: FIFO models around the stage, scoreboard fed by a
// frame-level reference model of the conversion rules.
module tb_pixel_convert_stage;
    localparam int PIX_W = 8;
    localparam int FP    = 4;
    localparam int CNT_W = 3;

    typedef struct {
        logic [23:0] pix;
        logic        eof;
        int          cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  thresh = 8'd0;
    logic        frame_done;
    logic [CNT_W-1:0] pixel_count;
    logic        full_drv = 1'b0;

    pixel_convert_stage_if #(.PIX_W(PIX_W)) fifo_bus ();

    pixel_convert_stage #(
        .PIX_W        (PIX_W),
        .FRAME_PIXELS (FP),
        .CNT_W        (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mode        (mode),
        .thresh      (thresh),
        .fifo        (fifo_bus),
        .frame_done  (frame_done),
        .pixel_count (pixel_count)
    );

    always #5 clock = ~clock;

    logic [23:0] in_q[$];
    exp_t        exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    int model_idx = 0;
    int lat_mode = 0;
    int lat_th = 0;
    logic done_exp = 1'b0;
    int cyc = 0;
    int rd_total = 0;
    int done_pulses = 0;
    bit chk_lat = 0;

    function automatic logic [23:0] ref_conv(input int m, input int th, input logic [23:0] p);
        int r, g, b, y, gv;
        logic [7:0] g8;
        r  = int'(p[23:16]);
        g  = int'(p[15:8]);
        b  = int'(p[7:0]);
        y  = (77*r + 150*g + 29*b) / 256;
        gv = 0;
        case (m)
            1: gv = (r + g + b) / 3;
            2: gv = y;
            3: gv = (y >= th) ? 255 : 0;
            default: gv = 0;
        endcase
        g8 = gv[7:0];
        return (m == 0) ? p : {g8, g8, g8};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: drive FIFO-side inputs, sample at the falling edge, update the model
    task automatic tick();
        logic  done_next;
        logic [23:0] p;
        exp_t  e;
        fifo_bus.fifo_in_empty = (in_q.size() == 0);
        fifo_bus.fifo_in_dout  = (in_q.size() != 0) ? in_q[0] : 24'h0;
        fifo_bus.fifo_out_full = full_drv;
        @(negedge clock);
        if (frame_done === 1'b1) done_pulses++;
        if (reset) begin
            check("rst_rd_en", {31'b0, fifo_bus.fifo_in_rd_en}, 32'd0);
            check("rst_wr_en", {31'b0, fifo_bus.fifo_out_wr_en}, 32'd0);
            check("rst_count", 32'(pixel_count), 32'd0);
            check("rst_done", {31'b0, frame_done}, 32'd0);
            check("rst_din", 32'(fifo_bus.fifo_out_din), 32'd0);
            exp_q.delete();
            model_idx = 0;
            done_exp  = 1'b0;
        end else begin
            check("pixel_count", 32'(pixel_count), 32'(model_idx));
            check("frame_done", {31'b0, frame_done}, {31'b0, done_exp});
            check("rd_en", {31'b0, fifo_bus.fifo_in_rd_en},
                  {31'b0, (in_q.size() != 0) && (exp_q.size() < 2 || !full_drv)});
            if (exp_q.size() == 0)
                check("spurious_wr", {31'b0, fifo_bus.fifo_out_wr_en}, 32'd0);
            done_next = 1'b0;
            if (fifo_bus.fifo_out_wr_en === 1'b1 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_pixel", 32'(fifo_bus.fifo_out_din), 32'(e.pix));
                if (chk_lat) check("latency", 32'(cyc - e.cyc), 32'd2);
                done_next = e.eof;
            end
            if (fifo_bus.fifo_in_rd_en === 1'b1 && in_q.size() != 0) begin
                p = in_q.pop_front();
                if (model_idx == 0) begin
                    lat_mode = int'(mode);
                    lat_th   = int'(thresh);
                end
                e.pix = ref_conv(lat_mode, lat_th, p);
                e.eof = (model_idx == FP - 1);
                e.cyc = cyc;
                exp_q.push_back(e);
                model_idx = (model_idx + 1) % FP;
                rd_total++;
            end
            done_exp = done_next;
        end
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int budget;
        budget = 3000;
        while ((in_q.size() != 0 || exp_q.size() != 0) && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check("drain_timeout", 32'(in_q.size() + exp_q.size()), 32'd0);
        tick();
    endtask

    // Pad with random pixels so the next phase starts on a frame boundary
    task automatic align();
        int n;
        n = (FP - model_idx) % FP;
        for (int i = 0; i < n; i++) in_q.push_back(24'($urandom));
        drain();
    endtask

    initial begin
        int base, budget, pulses0;
        fifo_bus.fifo_in_empty = 1'b1;
        fifo_bus.fifo_in_dout  = 24'h0;
        fifo_bus.fifo_out_full = 1'b0;
        in_q.push_back(24'($urandom));
        @(posedge clock);
        #1;
        repeat (3) tick();
        reset = 1'b0;

        // Reset with two pixels held in the stalled pipeline
        mode = 2'd2;
        full_drv = 1'b1;
        repeat (3) in_q.push_back(24'($urandom));
        base = rd_total;
        repeat (4) tick();
        check("absorbed", 32'(rd_total - base), 32'd2);
        mode  = 2'd1;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        full_drv = 1'b0;
        drain();
        align();

        // PASS: bit-exact, 2-cycle latency, back-to-back
        chk_lat = 1;
        mode = 2'd0;
        in_q.push_back(24'h123456);
        in_q.push_back(24'hFFFFFF);
        in_q.push_back(24'h000000);
        in_q.push_back(24'($urandom));
        drain();

        // AVG: directed values then every channel sum 0..765
        mode = 2'd1;
        in_q.push_back(24'hFFFFFF);
        in_q.push_back(24'h010101);
        in_q.push_back(24'h020100);
        in_q.push_back(24'hFF0000);
        for (int s = 0; s <= 765; s++) begin
            int r, g, b, rem;
            r   = $urandom_range((s > 255) ? 255 : s, (s > 510) ? s - 510 : 0);
            rem = s - r;
            g   = $urandom_range((rem > 255) ? 255 : rem, (rem > 255) ? rem - 255 : 0);
            b   = rem - g;
            in_q.push_back({r[7:0], g[7:0], b[7:0]});
        end
        drain();
        align();

        // LUMA
        mode = 2'd2;
        in_q.push_back(24'hFF0000);
        in_q.push_back(24'h00FF00);
        in_q.push_back(24'h0000FF);
        in_q.push_back(24'hFFFFFF);
        repeat (40) in_q.push_back(24'($urandom));
        drain();
        align();

        // THRESH
        mode = 2'd3;
        thresh = 8'h80;
        in_q.push_back(24'h808080);
        in_q.push_back(24'h7F7F7F);
        repeat (2) in_q.push_back(24'($urandom));
        drain();
        thresh = 8'($urandom);
        repeat (40) in_q.push_back(24'($urandom));
        drain();
        align();

        // Backpressure window mid-burst
        chk_lat = 0;
        mode = 2'd0;
        repeat (16) in_q.push_back(24'($urandom));
        repeat (3) tick();
        full_drv = 1'b1;
        repeat (10) tick();
        check("stall_inflight", 32'(exp_q.size()), 32'd2);
        full_drv = 1'b0;
        drain();
        align();

        // Random traffic, backpressure and mode/thresh churn
        repeat (300) begin
            if ($urandom_range(0, 2) == 0) in_q.push_back(24'($urandom));
            full_drv = 1'($urandom_range(0, 1));
            mode     = 2'($urandom_range(0, 3));
            thresh   = 8'($urandom);
            tick();
        end
        full_drv = 1'b0;
        drain();
        align();

        // Mode change at pixel 2 takes effect only from the next frame
        mode = 2'd1;
        pulses0 = done_pulses;
        base = rd_total;
        repeat (8) in_q.push_back(24'($urandom));
        budget = 50;
        while (rd_total < base + 2 && budget > 0) begin
            tick();
            budget--;
        end
        check("frame_reads", 32'(rd_total - base >= 2), 32'd1);
        mode = 2'd2;
        drain();
        check("frame_done_pulses", 32'(done_pulses - pulses0), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
